sad_accumulate_stage: RTL and testbench

- SAD1 execute stage of the pipelined MIPS SAD extension; sits directly downstream of the Memory/SAD1 pipeline register.
- Consumes the latched 16-lane window and frame vectors and computes their sum of absolute differences over several cycles.
- Returns a 32-bit result for write-back and stalls upstream while busy.
- Optionally tracks the minimum SAD and its candidate index across a search sequence.

---
 rtl/sad_pkg.sv | 23 ++
 rtl/sad_absdiff_tree.sv | 33 +++
 rtl/sad_accumulate_stage.sv | 164 ++++++++++++++++
 tb/tb_sad_accumulate_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD extension datapath.
// Used by sad_accumulate_stage and sad_absdiff_tree.
package sad_pkg;

    localparam int LANES           = 16;
    localparam int LANES_PER_CYCLE = 4;
    localparam int DATA_W          = 32;
    localparam int SUM_W           = 36;

    localparam logic [31:0] SAD_SAT_VALUE = 32'hFFFFFFFF;

    // Opcode encodings shared with the control unit.
    localparam logic [1:0] SAD_OP_WINDOW = 2'd3;
    localparam logic [1:0] SAD_OP_FRAME1 = 2'd1;
    localparam logic [1:0] SAD_OP_FRAME2 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } sad_state_e;

endpackage

// File: rtl/sad_absdiff_tree.sv
// Combinational sum of absolute differences over one lane group.
// Each |w - f| is formed as max - min, so it never wraps.
module sad_absdiff_tree
    import sad_pkg::*;
#(
    parameter int N  = LANES_PER_CYCLE,
    parameter int DW = DATA_W
) (
    input  logic [N*DW-1:0] WinGrp,
    input  logic [N*DW-1:0] FrmGrp,
    output logic [DW+1:0]   Sum
);

    logic [DW:0] diff [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        assign a = WinGrp[i*DW +: DW];
        assign b = FrmGrp[i*DW +: DW];
        assign diff[i] = (a >= b) ? ({1'b0, a} - {1'b0, b})
                                  : ({1'b0, b} - {1'b0, a});
    end

    // Adder chain over the lane differences.
    always_comb begin
        Sum = '0;
        for (int i = 0; i < N; i++) begin
            Sum = Sum + (DW+2)'(diff[i]);
        end
    end

endmodule

// File: rtl/sad_accumulate_stage.sv
// SAD1 execute stage: multi-cycle sum of absolute differences.
// Build option SAD_MIN_TRACK_EN adds the MinSAD/MinIdx tracker.
module sad_accumulate_stage
    import sad_pkg::*;
#(
    parameter int LANES_P = LANES,
    parameter int LPC     = LANES_PER_CYCLE,
    parameter int DW      = DATA_W,
    parameter int SW      = SUM_W
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [LANES_P*DW-1:0] WindowVec,
    input  logic [LANES_P*DW-1:0] FrameVec,
    input  logic [15:0]           CandIdx,
    input  logic                  Flush,
    input  logic                  MinClear,
    output logic                  Busy,
    output logic                  Done,
    output logic [31:0]           SADResult,
    output logic [31:0]           MinSAD,
    output logic [15:0]           MinIdx
);

    localparam int VEC_W = LANES_P * DW;
    localparam int GRP_W = LPC * DW;
    localparam int CNT_W = $clog2(LANES_P);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES_P - LPC);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(LPC);

    sad_state_e state_q;
    sad_state_e state_d;

    logic [VEC_W-1:0] win_q;
    logic [VEC_W-1:0] frm_q;
    logic [SW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      res_q;

    logic [GRP_W-1:0] win_grp;
    logic [GRP_W-1:0] frm_grp;
    logic [DW+1:0]    grp_sum;
    logic [SW-1:0]    acc_next;
    logic [31:0]      sat_res;

    logic accept;
    logic step;
    logic last;
    logic finish;

    assign win_grp = win_q[int'(cnt_q)*DW +: GRP_W];
    assign frm_grp = frm_q[int'(cnt_q)*DW +: GRP_W];

    sad_absdiff_tree #(
        .N  (LPC),
        .DW (DW)
    ) u_tree (
        .WinGrp (win_grp),
        .FrmGrp (frm_grp),
        .Sum    (grp_sum)
    );

    assign acc_next = acc_q + SW'(grp_sum);
    assign sat_res  = (|acc_next[SW-1:32]) ? SAD_SAT_VALUE
                                           : acc_next[31:0];

    assign last   = (cnt_q == LAST_CNT);
    assign accept = (state_q == S_IDLE) && Start && !Flush;
    assign step   = (state_q == S_ACCUM) && !Flush;
    assign finish = step && last;

    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign SADResult = res_q;

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Start) state_d = S_ACCUM;
            S_ACCUM: if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Flush) begin
            state_d = S_IDLE;
        end
    end

    // Operand capture, accumulation and result commit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            win_q <= '0;
            frm_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                win_q <= WindowVec;
                frm_q <= FrameVec;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (step) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + CNT_STEP;
            end
            if (finish) begin
                res_q <= sat_res;
            end
        end
    end

`ifdef SAD_MIN_TRACK_EN

    logic [15:0] idx_q;
    logic [31:0] min_q;
    logic [15:0] min_idx_q;

    // Minimum tracker; a clear beats a coincident completion.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idx_q     <= '0;
            min_q     <= SAD_SAT_VALUE;
            min_idx_q <= '0;
        end else begin
            if (accept) begin
                idx_q <= CandIdx;
            end
            if (MinClear) begin
                min_q     <= SAD_SAT_VALUE;
                min_idx_q <= '0;
            end else if (Done && !Flush && (res_q < min_q)) begin
                min_q     <= res_q;
                min_idx_q <= idx_q;
            end
        end
    end

    assign MinSAD = min_q;
    assign MinIdx = min_idx_q;

`else

    logic unused_min;
    assign unused_min = ^{MinClear, CandIdx};

    assign MinSAD = SAD_SAT_VALUE;
    assign MinIdx = '0;

`endif

endmodule

// File: tb/tb_sad_accumulate_stage.sv
// Directed bench for sad_accumulate_stage.
// Min-tracker steps are built only with SAD_MIN_TRACK_EN.
module tb_sad_accumulate_stage;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [511:0] WindowVec;
    logic [511:0] FrameVec;
    logic [15:0]  CandIdx;
    logic         Flush;
    logic         MinClear;
    logic         Busy;
    logic         Done;
    logic [31:0]  SADResult;
    logic [31:0]  MinSAD;
    logic [15:0]  MinIdx;

    int n_cmp = 0;
    int n_err = 0;

    sad_accumulate_stage dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .WindowVec (WindowVec),
        .FrameVec  (FrameVec),
        .CandIdx   (CandIdx),
        .Flush     (Flush),
        .MinClear  (MinClear),
        .Busy      (Busy),
        .Done      (Done),
        .SADResult (SADResult),
        .MinSAD    (MinSAD),
        .MinIdx    (MinIdx)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] fill(input logic [31:0] v);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
        return r;
    endfunction

    function automatic logic [511:0] ramp();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(i);
        return r;
    endfunction

    function automatic logic [511:0] rev();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'(15 - i);
        return r;
    endfunction

    function automatic logic [511:0] one(input int lane,
                                         input logic [31:0] v);
        logic [511:0] r;
        r = '0;
        r[lane*32 +: 32] = v;
        return r;
    endfunction

    // Start one op, wait for Done (bounded), check latency and result,
    // then step one more cycle so the stage is back in IDLE.
    task automatic run_op(input logic [511:0] w,
                          input logic [511:0] f,
                          input logic [15:0]  idx,
                          input logic [31:0]  exp,
                          input string        tag);
        int lat;
        @(negedge Clk);
        WindowVec = w;
        FrameVec  = f;
        CandIdx   = idx;
        Start     = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat   = 1;
        while (!Done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 5);
        check({tag, "_res"}, SADResult, exp);
        @(negedge Clk);
    endtask

    initial begin
        int t;
        int d;
        int seen;

        Reset     = 1'b0;
        Start     = 1'b0;
        Flush     = 1'b0;
        MinClear  = 1'b0;
        CandIdx   = '0;
        WindowVec = '0;
        FrameVec  = '0;

        #12;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_res", SADResult, 0);
        check("rst_min", MinSAD, 32'hFFFFFFFF);
        check("rst_minidx", MinIdx, 0);
        @(negedge Clk);
        Reset = 1'b1;

        // 10 vs 3 on all lanes: 16*7 = 112, cycle-by-cycle timing.
        @(negedge Clk);
        WindowVec = fill(32'd10);
        FrameVec  = fill(32'd3);
        Start     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            Start = 1'b0;
            check($sformatf("t1_busy_c%0d", c), Busy, (c <= 5) ? 1 : 0);
            check($sformatf("t1_done_c%0d", c), Done, (c == 5) ? 1 : 0);
            if (c == 5) check("t1_res", SADResult, 32'd112);
        end

        // |2i-15| summed over 16 lanes = 128, both orders.
        run_op(ramp(), rev(), 16'd0, 32'd128, "ramp");
        run_op(rev(), ramp(), 16'd0, 32'd128, "swap");

        // 16*(2^32-1) overflows 32 bits: saturate.
        run_op(fill(32'hFFFFFFFF), fill(32'h0), 16'd0,
               32'hFFFFFFFF, "sat");

        // Start held through Busy; operands change mid-ACCUM.
        @(negedge Clk);
        WindowVec = fill(32'd10);
        FrameVec  = fill(32'd3);
        Start     = 1'b1;
        @(negedge Clk);
        WindowVec = ramp();
        FrameVec  = rev();
        t = 1;
        while (!Done && t < 20) begin
            @(negedge Clk);
            t++;
        end
        check("hold_lat1", t, 5);
        check("hold_res1", SADResult, 32'd112);
        d = 0;
        do begin
            @(negedge Clk);
            d++;
            if (d == 2) Start = 1'b0;
        end while (!Done && d < 20);
        check("hold_gap", d, 6);
        check("hold_res2", SADResult, 32'd128);
        @(negedge Clk);

        // Flush in cycle 2 of an op: no Done, result holds.
        run_op(fill(32'd10), fill(32'd3), 16'd0, 32'd112, "preflush");
        @(negedge Clk);
        WindowVec = ramp();
        FrameVec  = rev();
        Start     = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (Done) seen++;
        end
        check("flush_nodone", seen, 0);
        check("flush_res", SADResult, 32'd112);

        // Flush wins over Start in the same cycle.
        @(negedge Clk);
        Start = 1'b1;
        Flush = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_busy", Busy, 0);

`ifdef SAD_MIN_TRACK_EN
        @(negedge Clk);
        MinClear = 1'b1;
        @(negedge Clk);
        MinClear = 1'b0;
        check("min_clr0", MinSAD, 32'hFFFFFFFF);
        run_op(one(0, 32'd200), '0, 16'd7, 32'd200, "cand7");
        check("min_after7", MinSAD, 32'd200);
        check("idx_after7", MinIdx, 16'd7);
        run_op(one(5, 32'd50), '0, 16'd9, 32'd50, "cand9");
        run_op(one(11, 32'd50), '0, 16'd4, 32'd50, "cand4");
        check("min_final", MinSAD, 32'd50);
        check("idx_final", MinIdx, 16'd9);
        @(negedge Clk);
        MinClear = 1'b1;
        @(negedge Clk);
        MinClear = 1'b0;
        check("min_clr", MinSAD, 32'hFFFFFFFF);
        check("idx_clr", MinIdx, 0);
`else
        check("min_tied", MinSAD, 32'hFFFFFFFF);
        check("idx_tied", MinIdx, 0);
`endif

        // Asynchronous reset in mid-ACCUM, between clock edges.
        @(negedge Clk);
        WindowVec = fill(32'd10);
        FrameVec  = fill(32'd3);
        Start     = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_res", SADResult, 0);
        check("arst_min", MinSAD, 32'hFFFFFFFF);
        @(negedge Clk);
        Reset = 1'b1;
        run_op(fill(32'd5), fill(32'd9), 16'd0, 32'd64, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
